// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch flushes,
// dmem freeze with timeout, and saturating stall/flush counters.
module hazard_ctrl #(
  parameter int MAX_WAIT = 255,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             mem_branch_taken,
  input  logic             dmem_busy,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_bubble,
  output logic             ex_mem_write,
  output logic             ex_mem_flush,
  output logic             mem_wb_write,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic             timeout_err
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FREEZE = 2'd1
  } fsm_t;

  localparam int WW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WW-1:0] WLAST = WW'(MAX_WAIT - 1);

  fsm_t          fsm;
  logic          pending_flush;
  logic [WW-1:0] wait_cnt;

  logic freeze;
  logic flush;
  logic rs_match;
  logic load_use;

  assign freeze   = ~reset & dmem_busy;
  assign flush    = ~reset & ~freeze
                  & (mem_branch_taken | pending_flush);
  assign rs_match = (id_uses_rs1 & (id_rs1 == ex_rd))
                  | (id_uses_rs2 & (id_rs2 == ex_rd));
  assign load_use = ~reset & ~freeze & ~flush
                  & ex_mem_read & (ex_rd != 5'd0) & rs_match;

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_write  = 1'b1;
    id_ex_bubble = 1'b0;
    ex_mem_write = 1'b1;
    ex_mem_flush = 1'b0;
    mem_wb_write = 1'b1;
    unique case (1'b1)
      reset, flush: begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        ex_mem_flush = 1'b1;
      end
      freeze: begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_write  = 1'b0;
        ex_mem_write = 1'b0;
        mem_wb_write = 1'b0;
      end
      load_use: begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  assign state = fsm;

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm           <= RUN;
      pending_flush <= 1'b0;
      wait_cnt      <= '0;
      stall_cycles  <= '0;
      flush_events  <= '0;
      timeout_err   <= 1'b0;
    end else begin
      if (freeze) begin
        fsm <= FREEZE;
        if (wait_cnt == WLAST) timeout_err <= 1'b1;
        else wait_cnt <= wait_cnt + WW'(1);
        if (mem_branch_taken) pending_flush <= 1'b1;
      end else begin
        fsm      <= RUN;
        wait_cnt <= '0;
      end
      if (flush) begin
        pending_flush <= 1'b0;
        if (flush_events != '1)
          flush_events <= flush_events + CNT_W'(1);
      end
      // freeze and load-use are the only sources of pc_write=0
      if (~pc_write && stall_cycles != '1)
        stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with hand-computed control vectors
// and counter values; small MAX_WAIT/CNT_W to reach the boundaries.
module tb_hazard_ctrl;

  localparam int CW = 4;

  localparam logic [7:0] C_RST  = 8'hFF;
  localparam logic [7:0] C_IDLE = 8'hD5;
  localparam logic [7:0] C_FRZ  = 8'h00;
  localparam logic [7:0] C_FLSH = 8'hFF;
  localparam logic [7:0] C_LU   = 8'h1D;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          id_uses_rs1, id_uses_rs2;
  logic          ex_mem_read, mem_branch_taken, dmem_busy;
  logic          pc_write, if_id_write, if_id_flush;
  logic          id_ex_write, id_ex_bubble;
  logic          ex_mem_write, ex_mem_flush, mem_wb_write;
  logic [1:0]    state;
  logic [CW-1:0] stall_cycles, flush_events;
  logic          timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  hazard_ctrl #(.MAX_WAIT(4), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .mem_branch_taken(mem_branch_taken), .dmem_busy(dmem_busy),
    .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .id_ex_write(id_ex_write),
    .id_ex_bubble(id_ex_bubble), .ex_mem_write(ex_mem_write),
    .ex_mem_flush(ex_mem_flush), .mem_wb_write(mem_wb_write),
    .state(state), .stall_cycles(stall_cycles),
    .flush_events(flush_events), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ctl();
    return {pc_write, if_id_write, if_id_flush, id_ex_write,
            id_ex_bubble, ex_mem_write, ex_mem_flush, mem_wb_write};
  endfunction

  task automatic idle();
    reset = 0; id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; ex_mem_read = 0;
    mem_branch_taken = 0; dmem_busy = 0;
  endtask

  // check control outputs for the applied inputs, then clock once
  task automatic cyc(input string tag, input logic [7:0] exp);
    #1 chk(tag, 32'(ctl()), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic regs(input string tag, input logic [1:0] st,
                      input int stl, input int fl, input logic to);
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".stall"}, 32'(stall_cycles), 32'(stl));
    chk({tag, ".flush"}, 32'(flush_events), 32'(fl));
    chk({tag, ".tmo"}, 32'(timeout_err), 32'(to));
  endtask

  initial begin
    idle();
    reset = 1;
    @(posedge clk); #1;
    cyc("rst_ctl", C_RST);
    idle();
    regs("after_rst", 2'd0, 0, 0, 1'b0);
    cyc("idle", C_IDLE);

    ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
    cyc("lu_rs1", C_LU);
    idle();
    cyc("lu_next", C_IDLE);
    regs("lu", 2'd0, 1, 0, 1'b0);

    ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_uses_rs1 = 1;
    cyc("x0_nostall", C_IDLE);
    idle();
    ex_mem_read = 1; ex_rd = 7; id_rs2 = 7; id_uses_rs2 = 0;
    cyc("rs2_unused", C_IDLE);
    id_uses_rs2 = 1;
    cyc("lu_rs2", C_LU);
    idle();
    regs("lu2", 2'd0, 2, 0, 1'b0);

    mem_branch_taken = 1;
    ex_mem_read = 1; ex_rd = 3; id_rs1 = 3; id_uses_rs1 = 1;
    cyc("br_over_lu", C_FLSH);
    idle();
    regs("br", 2'd0, 2, 1, 1'b0);
    cyc("br_once", C_IDLE);

    dmem_busy = 1;
    cyc("frz1", C_FRZ);
    chk("frz1.state", 32'(state), 32'd1);
    mem_branch_taken = 1;
    cyc("frz2_br", C_FRZ);
    mem_branch_taken = 0;
    cyc("frz3", C_FRZ);
    regs("frz", 2'd1, 5, 1, 1'b0);
    dmem_busy = 0;
    cyc("deferred_flush", C_FLSH);
    regs("frz_end", 2'd0, 5, 2, 1'b0);
    cyc("frz_idle", C_IDLE);

    dmem_busy = 1;
    for (int i = 1; i <= 6; i++) begin
      cyc("tmo_frz", C_FRZ);
      if (i == 3) chk("tmo_c3", 32'(timeout_err), 32'd0);
      if (i == 4) chk("tmo_c4", 32'(timeout_err), 32'd1);
    end
    dmem_busy = 0;
    cyc("tmo_release", C_IDLE);
    regs("tmo", 2'd0, 11, 2, 1'b1);

    dmem_busy = 1;
    for (int i = 0; i < 6; i++) cyc("sat_frz", C_FRZ);
    dmem_busy = 0;
    cyc("sat_release", C_IDLE);
    regs("sat", 2'd0, 15, 2, 1'b1);

    dmem_busy = 1; mem_branch_taken = 1;
    cyc("rmf1", C_FRZ);
    mem_branch_taken = 0;
    cyc("rmf2", C_FRZ);
    dmem_busy = 0; reset = 1;
    cyc("rmf_rst", C_RST);
    idle();
    regs("rmf", 2'd0, 0, 0, 1'b0);
    cyc("rmf_nopend", C_IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
